// File: rtl/sequenciador_pilha_if.sv
// sequenciador_pilha_if -- instruction channel of the stack sequencer.
//   instr_valid : instruction offered this cycle (master -> slave)
//   instr_ready : sequencer can accept an instruction (slave -> master)
//   instr_op    : 00 NOP, 01 PUSH imm, 10 POP, 11 ALU
//   instr_alu   : ALU opcode, meaningful only for ALU instructions
//   instr_imm   : immediate value for PUSH
interface sequenciador_pilha_if #(
  parameter int W = 8
);
  logic         instr_valid;
  logic         instr_ready;
  logic [1:0]   instr_op;
  logic [4:0]   instr_alu;
  logic [W-1:0] instr_imm;

  modport master (
    output instr_valid, instr_op, instr_alu, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_alu, instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/sequenciador_pilha.sv
// sequenciador_pilha -- control FSM for a stack/ALU datapath.
// Accepts NOP/PUSH/POP/ALU instructions over a valid/ready channel and
// sequences one-cycle push/pop/load strobes to the external stack and
// temp-register datapath, tracking stack occupancy internally.
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : instruction channel (slave side)
//   push/pop/load : one-cycle datapath strobes, mutually exclusive
//   opcode     : ALU opcode, held from POP_A through WB
//   din        : stack write data (immediate or ALU result)
//   s_ula, carryout : ALU result and carry from datapath
//   empty, full     : stack status from datapath
//   carry_flag : carry captured at ALU write-back
//   done / err : completion / rejection pulses
//   count      : internal stack occupancy
//
// state | meaning
// IDLE  | waiting for an instruction, instr_ready=1
// PUSH  | push immediate
// POP   | discard top of stack
// POP_A | pop first operand
// LD_A  | load first operand into temp register
// POP_B | pop second operand
// LD_B  | load second operand into temp register
// EXEC  | ALU settle cycle, no strobe
// WB    | push ALU result, capture carry
// DONE  | completion pulse
// ERR   | rejection pulse
module sequenciador_pilha #(
  parameter  int DEPTH = 8,
  parameter  int W     = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  sequenciador_pilha_if.slave   bus,
  output logic                  push,
  output logic                  pop,
  output logic                  load,
  output logic [4:0]            opcode,
  output logic [W-1:0]          din,
  input  logic [W-1:0]          s_ula,
  input  logic                  carryout,
  input  logic                  empty,
  input  logic                  full,
  output logic                  carry_flag,
  output logic                  done,
  output logic                  err,
  output logic [CW-1:0]         count
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_PUSH  = 4'd1;
  localparam logic [3:0] S_POP   = 4'd2;
  localparam logic [3:0] S_POP_A = 4'd3;
  localparam logic [3:0] S_LD_A  = 4'd4;
  localparam logic [3:0] S_POP_B = 4'd5;
  localparam logic [3:0] S_LD_B  = 4'd6;
  localparam logic [3:0] S_EXEC  = 4'd7;
  localparam logic [3:0] S_WB    = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;
  localparam logic [3:0] S_ERR   = 4'd10;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);

  logic [3:0]    state, state_nx;
  logic [4:0]    alu_q;
  logic [W-1:0]  imm_q;
  logic [CW-1:0] cnt;
  logic          carry_q;
  logic          accept;

  assign accept = bus.instr_valid && (state == S_IDLE);

  // The instruction type is captured by the branch taken out of IDLE, so
  // only the ALU opcode and immediate need their own holding registers.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.instr_valid) begin
          case (bus.instr_op)
            OP_NOP:  state_nx = S_DONE;
            OP_PUSH: state_nx = (cnt == CNT_FULL || full)  ? S_ERR : S_PUSH;
            OP_POP:  state_nx = (cnt == '0 || empty)       ? S_ERR : S_POP;
            default: state_nx = (cnt < CNT_TWO)            ? S_ERR : S_POP_A;
          endcase
        end
      end
      S_PUSH:  state_nx = S_DONE;
      S_POP:   state_nx = S_DONE;
      S_POP_A: state_nx = S_LD_A;
      S_LD_A:  state_nx = S_POP_B;
      S_POP_B: state_nx = S_LD_B;
      S_LD_B:  state_nx = S_EXEC;
      S_EXEC:  state_nx = S_WB;
      S_WB:    state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      alu_q   <= '0;
      imm_q   <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        alu_q <= bus.instr_alu;
        imm_q <= bus.instr_imm;
      end
      // Occupancy follows the strobes themselves; guards on entry keep it
      // from ever wrapping.
      case (state)
        S_PUSH, S_WB:           cnt <= cnt + CNT_ONE;
        S_POP, S_POP_A, S_POP_B: cnt <= cnt - CNT_ONE;
        default: ;
      endcase
      if (state == S_WB) carry_q <= carryout;
    end
  end

  // Outputs are decoded from state and forced low while rst is high so a
  // reset aborts an instruction without any further strobe.
  always_comb begin
    push   = 1'b0;
    pop    = 1'b0;
    load   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    opcode = '0;
    din    = '0;
    if (!rst) begin
      case (state)
        S_PUSH: begin
          push = 1'b1;
          din  = imm_q;
        end
        S_POP:   pop = 1'b1;
        S_POP_A: pop = 1'b1;
        S_LD_A:  load = 1'b1;
        S_POP_B: pop = 1'b1;
        S_LD_B:  load = 1'b1;
        S_WB: begin
          push = 1'b1;
          din  = s_ula;
        end
        S_DONE:  done = 1'b1;
        S_ERR:   err = 1'b1;
        default: ;
      endcase
      if (state >= S_POP_A && state <= S_WB) opcode = alu_q;
    end
  end

  assign bus.instr_ready = !rst && (state == S_IDLE);
  assign carry_flag      = carry_q;
  assign count           = cnt;

endmodule
